// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and types for the register-file writeback arbiter
//
// Contents:
//   DATA_W, ADDR_W, NUM_REGS  default register-file geometry
//   wb_req_t                  one pending writeback {addr, data}
//   REG_ZERO                  hard-wired zero register; writes to it are dropped
package rf_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_slot.sv
// rtl/wb_slot.sv - one-entry writeback holding slot
//
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous active-high reset, empties the slot
//   load      store load_req this cycle (wins over clear)
//   clear     entry has been granted; empty the slot unless reloaded
//   load_req  request to store
//   full      slot holds a valid entry
//   req       stored entry
module wb_slot
  import rf_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    load,
  input  logic    clear,
  input  wb_req_t load_req,
  output logic    full,
  output wb_req_t req
);

  // A load in the same cycle as a clear replaces the outgoing entry, so a
  // streaming source sees no bubble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      req  <= '0;
    end else if (load) begin
      full <= 1'b1;
      req  <= load_req;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-source arbiter for the register-file write port
//
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   s0_valid/ready/addr/data ALU/CSR writeback request (valid/ready handshake)
//   s1_valid/ready/addr/data load writeback request (valid/ready handshake)
//   rf_write/addr/data       registered register-file write port
//   pending_mask             bit i set while a write to register i is buffered
module rf_wb_arbiter #(
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                s0_valid,
  output logic                s0_ready,
  input  logic [ADDR_W-1:0]   s0_addr,
  input  logic [DATA_W-1:0]   s0_data,
  input  logic                s1_valid,
  output logic                s1_ready,
  input  logic [ADDR_W-1:0]   s1_addr,
  input  logic [DATA_W-1:0]   s1_data,
  output logic                rf_write,
  output logic [ADDR_W-1:0]   rf_addr,
  output logic [DATA_W-1:0]   rf_data,
  output logic [NUM_REGS-1:0] pending_mask
);

  import rf_pkg::*;

  wb_req_t in0, in1, slot0, slot1;
  logic    full0, full1;
  logic    ld0, ld1;
  logic    g0, g1;
  logic    tie;     // both slots were loaded on the same edge
  logic    old0;    // slot 0 is older than slot 1 (meaningful when !tie)
  logic    rr_ptr;  // slot to favour on a same-cycle, different-address tie
  logic    rr_toggle;

  assign in0 = '{addr: s0_addr, data: s0_data};
  assign in1 = '{addr: s1_addr, data: s1_data};

  // Writes to the zero register complete the handshake but are never stored.
  assign ld0 = s0_valid && s0_ready && (s0_addr != REG_ZERO);
  assign ld1 = s1_valid && s1_ready && (s1_addr != REG_ZERO);

  // Grants depend only on registered slot state, keeping valid off the ready path.
  always_comb begin
    g0        = 1'b0;
    g1        = 1'b0;
    rr_toggle = 1'b0;
    if (full0 && full1) begin
      if (!tie) begin
        g0 = old0;
        g1 = !old0;
      end else if (slot0.addr == slot1.addr) begin
        // Same-cycle same-address: s1 is treated as younger so its value lands last.
        g0 = 1'b1;
      end else begin
        g0        = !rr_ptr;
        g1        = rr_ptr;
        rr_toggle = 1'b1;
      end
    end else begin
      g0 = full0;
      g1 = full1;
    end
  end

  assign s0_ready = !full0 || g0;
  assign s1_ready = !full1 || g1;

  wb_slot u_slot0 (
    .clock    (clock),
    .reset    (reset),
    .load     (ld0),
    .clear    (g0),
    .load_req (in0),
    .full     (full0),
    .req      (slot0)
  );

  wb_slot u_slot1 (
    .clock    (clock),
    .reset    (reset),
    .load     (ld1),
    .clear    (g1),
    .load_req (in1),
    .full     (full1),
    .req      (slot1)
  );

  // Age tracking: a slot loaded alone is younger than anything still held in
  // the other slot; if the other slot drains at the same edge the flag is moot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tie    <= 1'b0;
      old0   <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      if (rr_toggle)
        rr_ptr <= !rr_ptr;
      if (ld0 && ld1) begin
        tie <= 1'b1;
      end else if (ld0) begin
        tie  <= 1'b0;
        old0 <= 1'b0;
      end else if (ld1) begin
        tie  <= 1'b0;
        old0 <= 1'b1;
      end
    end
  end

  // Address/data hold when idle so the falling-edge register-file write
  // always sees stable values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_write <= 1'b0;
      rf_addr  <= '0;
      rf_data  <= '0;
    end else if (g0 || g1) begin
      rf_write <= 1'b1;
      rf_addr  <= g0 ? slot0.addr : slot1.addr;
      rf_data  <= g0 ? slot0.data : slot1.data;
    end else begin
      rf_write <= 1'b0;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 1; i < NUM_REGS; i++)
      pending_mask[i] = (full0 && (slot0.addr == ADDR_W'(i))) ||
                        (full1 && (slot1.addr == ADDR_W'(i)));
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

  logic        clock;
  logic        reset;
  logic        s0_valid, s0_ready, s1_valid, s1_ready;
  logic [4:0]  s0_addr, s1_addr, rf_addr;
  logic [31:0] s0_data, s1_data, rf_data;
  logic        rf_write;
  logic [31:0] pending_mask;

  rf_wb_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .s0_valid     (s0_valid),
    .s0_ready     (s0_ready),
    .s0_addr      (s0_addr),
    .s0_data      (s0_data),
    .s1_valid     (s1_valid),
    .s1_ready     (s1_ready),
    .s1_addr      (s1_addr),
    .s1_data      (s1_data),
    .rf_write     (rf_write),
    .rf_addr      (rf_addr),
    .rf_data      (rf_data),
    .pending_mask (pending_mask)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    int          nexp;
    logic [4:0]  ea0;
    logic [31:0] ed0;
    logic [4:0]  ea1;
    logic [31:0] ed1;
    logic [31:0] emask;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  wr_t         exp_q[$];
  wr_t         e;
  logic [31:0] rf_model [32];
  int          wr_count = 0;
  int          run_len = 0;
  int          max_run = 0;
  vec_t        tbl [6];
  int          saved;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    s0_addr  = '0;
    s1_addr  = '0;
    s0_data  = '0;
    s1_data  = '0;
  endtask

  // Scoreboard: every observed register-file write must match the head of exp_q.
  always @(negedge clock) begin
    if (rf_write === 1'b1) begin
      wr_count++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      rf_model[rf_addr] = rf_data;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write at %0t",
                 rf_addr, rf_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(rf_addr), 32'(e.a));
        chk("wr_data", rf_data, e.d);
      end
    end else begin
      run_len = 0;
    end
  end

  initial begin
    tbl[0] = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 2, 5'd3, 32'h11, 5'd4, 32'h22, 32'h18};
    tbl[1] = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 2, 5'd4, 32'h22, 5'd3, 32'h11, 32'h18};
    tbl[2] = '{1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB, 2, 5'd7, 32'hAA, 5'd7, 32'hBB, 32'h80};
    tbl[3] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 32'hFFFF, 0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0};
    tbl[4] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 32'h99, 1, 5'd9, 32'h99, 5'd0, 32'h0, 32'h200};
    tbl[5] = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 2, 5'd3, 32'h33, 5'd4, 32'h44, 32'h18};

    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_rf_write", 32'(rf_write), 32'd0);
    chk("reset_rf_addr", 32'(rf_addr), 32'd0);
    chk("reset_rf_data", rf_data, 32'd0);
    chk("reset_pending", pending_mask, 32'd0);
    reset = 1'b0;
    #1;
    chk("reset_s0_ready", 32'(s0_ready), 32'd1);
    chk("reset_s1_ready", 32'(s1_ready), 32'd1);

    // Single write: pending one cycle, rf_write for exactly one cycle.
    step();
    s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'hDEADBEEF;
    exp_q.push_back('{5'd5, 32'hDEADBEEF});
    step();
    idle();
    @(negedge clock);
    chk("t1_pending", pending_mask, 32'h20);
    chk("t1_no_write_yet", 32'(rf_write), 32'd0);
    @(negedge clock);
    chk("t1_write", 32'(rf_write), 32'd1);
    chk("t1_addr", 32'(rf_addr), 32'd5);
    chk("t1_data", rf_data, 32'hDEADBEEF);
    chk("t1_pending_clr", pending_mask, 32'd0);
    @(negedge clock);
    chk("t1_one_cycle", 32'(rf_write), 32'd0);
    chk("t1_addr_hold", 32'(rf_addr), 32'd5);
    step();

    // Table of single-cycle request pairs with hand-derived write order.
    for (int i = 0; i < 6; i++) begin
      s0_valid = tbl[i].v0; s0_addr = tbl[i].a0; s0_data = tbl[i].d0;
      s1_valid = tbl[i].v1; s1_addr = tbl[i].a1; s1_data = tbl[i].d1;
      if (tbl[i].nexp > 0) exp_q.push_back('{tbl[i].ea0, tbl[i].ed0});
      if (tbl[i].nexp > 1) exp_q.push_back('{tbl[i].ea1, tbl[i].ed1});
      chk($sformatf("v%0d_s0_ready", i), 32'(s0_ready), 32'd1);
      chk($sformatf("v%0d_s1_ready", i), 32'(s1_ready), 32'd1);
      step();
      idle();
      @(negedge clock);
      chk($sformatf("v%0d_pending", i), pending_mask, tbl[i].emask);
      repeat (4) step();
      chk($sformatf("v%0d_drained", i), 32'(exp_q.size()), 32'd0);
    end
    chk("same_addr_final_r7", rf_model[7], 32'hBB);

    // s1 accepted one cycle before s0 on the same register: s1 lands first.
    s1_valid = 1'b1; s1_addr = 5'd7; s1_data = 32'h0B;
    exp_q.push_back('{5'd7, 32'h0B});
    step();
    idle();
    s0_valid = 1'b1; s0_addr = 5'd7; s0_data = 32'h0A;
    exp_q.push_back('{5'd7, 32'h0A});
    step();
    idle();
    repeat (4) step();
    chk("s1_first_final_r7", rf_model[7], 32'h0A);

    // Tie won by s1 (rr_ptr=1), s1 reloads the register s0 still holds:
    // the older s0 entry must land before the new s1 entry.
    s0_valid = 1'b1; s0_addr = 5'd10; s0_data = 32'h100;
    s1_valid = 1'b1; s1_addr = 5'd11; s1_data = 32'h111;
    exp_q.push_back('{5'd11, 32'h111});
    exp_q.push_back('{5'd10, 32'h100});
    exp_q.push_back('{5'd10, 32'h222});
    step();
    idle();
    s1_valid = 1'b1; s1_addr = 5'd10; s1_data = 32'h222;
    chk("age_s1_ready_on_grant", 32'(s1_ready), 32'd1);
    step();
    idle();
    repeat (5) step();
    chk("age_final_r10", rf_model[10], 32'h222);
    chk("age_drained", 32'(exp_q.size()), 32'd0);

    // Back-to-back stream from s0 alone.
    max_run = 0;
    for (int i = 1; i <= 8; i++) begin
      s0_valid = 1'b1; s0_addr = 5'(i); s0_data = 32'h1000 + 32'(i);
      exp_q.push_back('{5'(i), 32'h1000 + 32'(i)});
      chk($sformatf("stream_ready_%0d", i), 32'(s0_ready), 32'd1);
      step();
    end
    idle();
    repeat (5) step();
    chk("stream_run_len", 32'(max_run), 32'd8);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while both slots are full and a write is on the port.
    s0_valid = 1'b1; s0_addr = 5'd12; s0_data = 32'hC0C0;
    s1_valid = 1'b1; s1_addr = 5'd13; s1_data = 32'hD0D0;
    step();
    idle();
    @(posedge clock);
    #3;
    chk("rst_pre_write", 32'(rf_write), 32'd1);
    saved = wr_count;
    reset = 1'b1;
    #1;
    chk("rst_write_drop", 32'(rf_write), 32'd0);
    chk("rst_pending", pending_mask, 32'd0);
    repeat (2) step();
    reset = 1'b0;
    repeat (6) step();
    chk("rst_no_stale_write", 32'(wr_count - saved), 32'd0);
    chk("rst_pending_after", pending_mask, 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
